mat_mul_cfg: RTL
================

# mat_mul_cfg

Parametrised successor to the lab matrix-multiply accelerator. It multiplies two square matrices whose dimension is chosen at run time, up to a synthesis-time maximum, and supports signed or unsigned operands. Both matrices arrive over one AXI-Stream slave; the product leaves over an AXI-Stream master with full backpressure. Configuration and start come from the AXI-Lite slave register bank; status flags go back to it.

## Interface
- DIM_LOG_MAX, 4: log2 of the largest supported dimension; memories hold 2^(2*DIM_LOG_MAX) words each.
- DATA_WIDTH, 16: operand width.
- ACC_WIDTH, 40: accumulator width; must be ≥ 2*DATA_WIDTH.
- OUT_WIDTH, 32: result word width, multiple of 8.
- s00_axi_aclk  in  1  single clock.
- s00_axi_areset  in  1  reset, synchronous, active-high.
- s00_axis_tready  out  1  slave ready.
- s00_axis_tdata  in  DATA_WIDTH  operand word.
- s00_axis_tlast  in  1  marks the final word of B.
- s00_axis_tvalid  in  1  slave valid.
- m00_axis_tvalid  out  1  master valid.
- m00_axis_tdata  out  OUT_WIDTH  result word.
- m00_axis_tstrb  out  OUT_WIDTH/8  constant all-ones.
- m00_axis_tlast  out  1  marks the final result word.
- m00_axis_tready  in  1  master ready.
- cfg_dim_log  in  $clog2(DIM_LOG_MAX+1)  dimension select; n = 2^cfg_dim_log. Values above DIM_LOG_MAX are clamped to DIM_LOG_MAX.
- cfg_signed  in  1  1 = two's-complement operands.
- start  in  1  single-cycle pulse from AXI-Lite.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- err_len  out  1  sticky tlast-mismatch flag; cleared on start.

## Operation
- Reset values: all outputs 0 except m00_axis_tstrb, which is all-ones. Reset returns the FSM to IDLE and clears all counters and flags. Memory contents are not cleared.
- **FSM states:** IDLE → LOAD_A → LOAD_B → COMPUTE → DRAIN → IDLE.
- **IDLE:**
  - start latches cfg_dim_log (clamped) and cfg_signed, clears err_len, and moves to LOAD_A.
  - start in any other state is ignored.
  - cfg_* changes outside the start cycle have no effect.
- **LOAD_A / LOAD_B:**
  - s00_axis_tready = 1.
  - Each handshake (tvalid & tready) writes the word row-major at the dense address r*n+c. The in-stream counter wraps at n*n.
  - n*n handshakes complete LOAD_A; n*n more complete LOAD_B.
  - tlast high on any beat other than the last B beat sets err_len. tlast low on the last B beat also sets err_len.
  - The transfer count, not tlast, governs the state transition.
  - No-valid cycles stall without side effects.
- **COMPUTE:**
  - Loop order is row, col, k; k is innermost.
  - One A and one B word are read per cycle at A[row*n+k] and B[k*n+col].
  - The read is registered, then the product is accumulated on the following cycle.
  - The accumulator starts at 0 for each (row, col). When k = n-1 it is saturated to OUT_WIDTH and written to R[row*n+col].
  - s00_axis_tready = 0.
- **Arithmetic:**
  - Products are DATA_WIDTH × DATA_WIDTH, signed or unsigned per the latched mode.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - Output saturates to the OUT_WIDTH signed range (signed mode) or unsigned range (unsigned mode).
- **DRAIN:**
  - R is read out in row-major order through a one-deep output register.
  - tdata and tlast are held stable while tvalid & !tready.
  - tlast is asserted on word n*n-1 only.
  - The handshake on that word moves the FSM to IDLE and pulses done.
- **n = 1:** a single-word A, a single-word B, one result with tlast = 1.

## Timing
- Load throughput: one word per cycle.
- COMPUTE lasts exactly n³+2 cycles: n³ read cycles plus two pipeline-flush cycles.
- First m00_axis_tvalid rises 2 cycles after entering DRAIN.
- With tready held high, DRAIN delivers one beat per cycle, with no bubbles across R-read boundaries. This requires prefetch of the next R word while the current one is held.
- After tready has been low, the output resumes on the cycle after tready rises. No word is lost or duplicated.
- done and the return to IDLE occur on the cycle after the final handshake.
- A new start is accepted in the cycle after done.
- Reset asserted during any state: the next cycle has tvalid = 0, tready = 0 and busy = 0.

## Test plan
- n=2, unsigned; A=[1,2;3,4], B=[5,6;7,8] → out 19,22,43,50; tlast on the 4th beat; done once; err_len=0.
- n=4, signed; A = identity×(-1), B with entries 0..15 → out is -B in row-major order; COMPUTE measured at 66 cycles.
- DATA_WIDTH=16, n=16 (max), signed; every element -32768 → each entry 16·2^30 saturates to 2147483647. Unsigned 0xFFFF everywhere → results saturate to 0xFFFFFFFF.
- Random tvalid gaps on input and random tready on output, n=8, compared against a reference model → no lost or duplicated beats; tdata stable while stalled.
- tlast on beat 3 of A with n=2 → err_len=1; results are still produced. The next start clears err_len.
- Reset pulsed mid-COMPUTE, then a clean n=1 run with A=3, B=-2 (signed) → single output -6, tlast=1.

Source files
------------

// File: rtl/mat_mul_cfg.sv
// Run-time-sized square matrix multiplier: A and B stream in over AXI-Stream,
// the saturated product streams out row-major with full backpressure.
module mat_mul_cfg #(
    parameter int unsigned DIM_LOG_MAX = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned OUT_WIDTH   = 32
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_areset,
    output logic                                   s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]                  s00_axis_tdata,
    input  logic                                   s00_axis_tlast,
    input  logic                                   s00_axis_tvalid,
    output logic                                   m00_axis_tvalid,
    output logic [OUT_WIDTH-1:0]                   m00_axis_tdata,
    output logic [OUT_WIDTH/8-1:0]                 m00_axis_tstrb,
    output logic                                   m00_axis_tlast,
    input  logic                                   m00_axis_tready,
    input  logic [$clog2(DIM_LOG_MAX+1)-1:0]       cfg_dim_log,
    input  logic                                   cfg_signed,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err_len
);

    localparam int unsigned DL    = DIM_LOG_MAX;
    localparam int unsigned AW    = 2 * DL;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = $clog2(DL + 1);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

    state_t                 state;
    logic [CW-1:0]          dim_log;
    logic                   sgn;
    logic [AW-1:0]          in_cnt;
    logic [AW-1:0]          rd_ptr;
    logic [DL-1:0]          row, col, k;
    logic                   rd_done, flush;
    logic                   s1_vld, s1_first, s1_last;
    logic [AW-1:0]          s1_raddr;
    logic [DW-1:0]          a_rd, b_rd;
    logic [ACC_WIDTH-1:0]   acc;
    logic [OUT_WIDTH-1:0]   pf_data;
    logic                   pf_vld, pf_last, rd_all;

    logic [DW-1:0]          mem_a [DEPTH];
    logic [DW-1:0]          mem_b [DEPTH];
    logic [OUT_WIDTH-1:0]   mem_r [DEPTH];

    logic [DL-1:0]          n_last;
    logic [AW-1:0]          nn_last;
    logic [CW-1:0]          cfg_clamp;
    logic                   in_hs, last_beat;
    logic [AW-1:0]          a_raddr, b_raddr;
    logic [PW-1:0]          a_ext, b_ext, prod;
    logic [ACC_WIDTH-1:0]   prod_ext, acc_sum;
    logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
    logic [OUT_WIDTH-1:0]   sat;
    logic                   out_hs, move, issue;

    assign m00_axis_tstrb = '1;

    // Derived sizes, addresses, MAC datapath and output-pipeline handshakes
    always_comb begin
        n_last    = DL'((32'd1 << dim_log) - 32'd1);
        nn_last   = AW'((32'd1 << (2 * 32'(dim_log))) - 32'd1);
        cfg_clamp = (cfg_dim_log > CW'(DL)) ? CW'(DL) : cfg_dim_log;
        in_hs     = s00_axis_tvalid & s00_axis_tready;
        last_beat = (state == LOAD_B) && (in_cnt == nn_last);
        a_raddr   = (AW'(row) << dim_log) | AW'(k);
        b_raddr   = (AW'(k) << dim_log) | AW'(col);

        a_ext    = {{DW{sgn & a_rd[DW-1]}}, a_rd};
        b_ext    = {{DW{sgn & b_rd[DW-1]}}, b_rd};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_WIDTH-PW){sgn & prod[PW-1]}}, prod};
        acc_sum  = (s1_first ? '0 : acc) + prod_ext;

        hi_bits = acc_sum[ACC_WIDTH-1:OUT_WIDTH-1];
        if (sgn) begin
            if ((hi_bits == '0) || (hi_bits == '1))
                sat = acc_sum[OUT_WIDTH-1:0];
            else if (acc_sum[ACC_WIDTH-1])
                sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            else
                sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            sat = (|acc_sum[ACC_WIDTH-1:OUT_WIDTH]) ? '1 : acc_sum[OUT_WIDTH-1:0];
        end

        out_hs = m00_axis_tvalid & m00_axis_tready;
        move   = pf_vld & (~m00_axis_tvalid | out_hs);
        issue  = (state == DRAIN) & ~rd_all & (~pf_vld | move);
    end

    // Operand/result memories and their registered read ports (never reset)
    always_ff @(posedge s00_axi_aclk) begin
        if (in_hs && state == LOAD_A) mem_a[in_cnt] <= s00_axis_tdata;
        if (in_hs && state == LOAD_B) mem_b[in_cnt] <= s00_axis_tdata;
        if (s1_vld && s1_last)        mem_r[s1_raddr] <= sat;
        a_rd <= mem_a[a_raddr];
        b_rd <= mem_b[b_raddr];
        if (issue) pf_data <= mem_r[rd_ptr];
    end

    // Control FSM, MAC pipeline and output register
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state           <= IDLE;
            dim_log         <= '0;
            sgn             <= 1'b0;
            in_cnt          <= '0;
            rd_ptr          <= '0;
            row             <= '0;
            col             <= '0;
            k               <= '0;
            rd_done         <= 1'b0;
            flush           <= 1'b0;
            s1_vld          <= 1'b0;
            s1_first        <= 1'b0;
            s1_last         <= 1'b0;
            s1_raddr        <= '0;
            acc             <= '0;
            pf_vld          <= 1'b0;
            pf_last         <= 1'b0;
            rd_all          <= 1'b0;
            s00_axis_tready <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_len         <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_vld   <= (state == COMPUTE) && !rd_done;
            s1_first <= (k == '0);
            s1_last  <= (k == n_last);
            s1_raddr <= (AW'(row) << dim_log) | AW'(col);
            if (s1_vld) acc <= acc_sum;

            case (state)
                IDLE: begin
                    if (start) begin
                        dim_log         <= cfg_clamp;
                        sgn             <= cfg_signed;
                        err_len         <= 1'b0;
                        in_cnt          <= '0;
                        s00_axis_tready <= 1'b1;
                        busy            <= 1'b1;
                        state           <= LOAD_A;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (in_hs) begin
                        if (s00_axis_tlast != last_beat) err_len <= 1'b1;
                        in_cnt <= in_cnt + AW'(1);
                        if (in_cnt == nn_last) begin
                            in_cnt <= '0;
                            if (state == LOAD_A) begin
                                state <= LOAD_B;
                            end else begin
                                state           <= COMPUTE;
                                s00_axis_tready <= 1'b0;
                                row             <= '0;
                                col             <= '0;
                                k               <= '0;
                                rd_done         <= 1'b0;
                                flush           <= 1'b0;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    if (!rd_done) begin
                        if (k == n_last) begin
                            k <= '0;
                            if (col == n_last) begin
                                col <= '0;
                                if (row == n_last) begin
                                    row     <= '0;
                                    rd_done <= 1'b1;
                                end else begin
                                    row <= row + DL'(1);
                                end
                            end else begin
                                col <= col + DL'(1);
                            end
                        end else begin
                            k <= k + DL'(1);
                        end
                    end else begin
                        // two flush cycles let the last product land in R
                        flush <= 1'b1;
                        if (flush) begin
                            state  <= DRAIN;
                            rd_ptr <= '0;
                            rd_all <= 1'b0;
                            pf_vld <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (move) begin
                        m00_axis_tdata  <= pf_data;
                        m00_axis_tlast  <= pf_last;
                        m00_axis_tvalid <= 1'b1;
                    end else if (out_hs) begin
                        m00_axis_tvalid <= 1'b0;
                    end
                    // prefetch keeps the next word ready behind the held one
                    if (issue) begin
                        pf_vld  <= 1'b1;
                        pf_last <= (rd_ptr == nn_last);
                        rd_ptr  <= rd_ptr + AW'(1);
                        if (rd_ptr == nn_last) rd_all <= 1'b1;
                    end else if (move) begin
                        pf_vld <= 1'b0;
                    end
                    if (out_hs && m00_axis_tlast) begin
                        m00_axis_tvalid <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
